// File: rtl/jtcontra_rom_arb.sv
// Round-robin arbiter sharing one SDRAM ROM read port between two CPU fetchers.
// Optional build macro: JTCONTRA_ARB_CACHE_EN keeps latched words valid across cs drops.
module jtcontra_rom_arb #(
    parameter int             AW0     = 17,
    parameter int             AW1     = 15,
    parameter int             MAW     = 18,
    parameter int             DW      = 8,
    parameter logic [MAW-1:0] OFFSET1 = 18'h20000
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           cs0,
    input  logic [AW0-1:0] addr0,
    output logic [DW-1:0]  dout0,
    output logic           ok0,
    input  logic           cs1,
    input  logic [AW1-1:0] addr1,
    output logic [DW-1:0]  dout1,
    output logic           ok1,
    output logic           mem_cs,
    output logic [MAW-1:0] mem_addr,
    input  logic [DW-1:0]  mem_data,
    input  logic           mem_ok
);
    localparam int TW = (AW0 > AW1) ? AW0 : AW1;

    typedef enum logic { IDLE, WAIT } state_t;

    state_t         state, state_nx;
    logic           settle, last, gnt;
    logic           valid0, valid1;
    logic [AW0-1:0] tag0;
    logic [AW1-1:0] tag1;
    logic [TW-1:0]  tag_next;
    logic           pend0, pend1;
    logic           issue, sel, done;

    assign ok0   = cs0 & valid0 & (tag0 == addr0);
    assign ok1   = cs1 & valid1 & (tag1 == addr1);
    assign pend0 = cs0 & ~ok0;
    assign pend1 = cs1 & ~ok1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        sel      = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (pend0 | pend1) begin
                issue    = 1'b1;
                sel      = (pend0 & pend1) ? ~last : pend1;
                state_nx = WAIT;
            end
            WAIT: if (!settle && mem_ok) begin
                // the first WAIT cycle may still see mem_ok from the previous access
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            dout0    <= '0;
            dout1    <= '0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            tag0     <= '0;
            tag1     <= '0;
            tag_next <= '0;
            settle   <= 1'b0;
            last     <= 1'b1;
            gnt      <= 1'b0;
        end else begin
            settle <= issue;
            if (issue) begin
                mem_cs   <= 1'b1;
                mem_addr <= sel ? MAW'(addr1) + OFFSET1 : MAW'(addr0);
                tag_next <= sel ? TW'(addr1) : TW'(addr0);
                gnt      <= sel;
                last     <= sel;
            end
            if (done) begin
                mem_cs <= 1'b0;
                if (!gnt) begin
                    dout0  <= mem_data;
                    tag0   <= tag_next[AW0-1:0];
                    valid0 <= 1'b1;
                end else begin
                    dout1  <= mem_data;
                    tag1   <= tag_next[AW1-1:0];
                    valid1 <= 1'b1;
                end
            end
`ifdef JTCONTRA_ARB_CACHE_EN
            // latched words stay usable after the requester deselects
`else
            if (!cs0) valid0 <= 1'b0;
            if (!cs1) valid1 <= 1'b0;
`endif
        end
    end
endmodule
